// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: default bus widths,
//   FSM state encoding and the "no write" code.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // Defaults track the core's data-memory geometry.
  localparam int AWIDTH_DEF = 12;
  localparam int XLEN_DEF   = 32;
  localparam int WEW_DEF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Write code meaning "read": ram only writes when the code is nonzero.
  localparam int unsigned WE_NONE = 0;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester's port into the data-memory arbiter.
//     req    requester -> arbiter  access request, held until ack
//     addr   requester -> arbiter  word address
//     wdata  requester -> arbiter  write data
//     we     requester -> arbiter  write/size code, 0 = read
//     ack    arbiter -> requester  one-cycle completion pulse
//     rdata  arbiter -> requester  read data, valid only while ack=1
//   master: the requester side.  slave: the arbiter side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int WEW    = WEW_DEF
);

  logic              req;
  logic [AWIDTH-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [WEW-1:0]    we;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, addr, wdata, we, input ack, rdata);
  modport slave  (input req, addr, wdata, we, output ack, rdata);

endinterface

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational two-way winner select.
//     req0, req1   pending requests
//     rr_ptr       requester favoured on a tie in round-robin mode
//     grant_id     winning requester (meaningful only with grant_valid)
//     grant_valid  at least one request is pending
//   FIXED_PRIO != 0 makes requester 0 win every tie.
// ---------------------------------------------------------------------------
module dmem_arb_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic grant_id,
  output logic grant_valid
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (req0 && req1) begin
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Serialises two requesters (core load/store path on m0, debug/loader on
//   m1) onto the single synchronous-read data-memory port.
//   One access every three cycles: IDLE (capture) -> ACCESS (ram samples)
//   -> RESP (ack + read data).
//     clk, rst     clock, synchronous active-high reset
//     m0, m1       requester ports (slave side)
//     mem_addr     address to ram (retained outside ACCESS)
//     mem_wdata    write data to ram (retained outside ACCESS)
//     mem_we       write code to ram, nonzero only in ACCESS
//     mem_rdata    ram read data, valid the cycle after the address
//     busy         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int WEW        = WEW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [WEW-1:0]    mem_we,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  state_t state;
  logic   win_id;   // requester owning the in-flight access
  logic   rr_ptr;   // requester favoured on the next tie
  logic   ack0_q;
  logic   ack1_q;
  logic   grant_id;
  logic   grant_valid;

  dmem_arb_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0        (m0.req),
    .req1        (m1.req),
    .rr_ptr      (rr_ptr),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (rst) begin
      state     <= ST_IDLE;
      win_id    <= 1'b0;
      rr_ptr    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= WEW'(WE_NONE);
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            win_id    <= grant_id;
            mem_addr  <= grant_id ? m1.addr  : m0.addr;
            mem_wdata <= grant_id ? m1.wdata : m0.wdata;
            mem_we    <= grant_id ? m1.we    : m0.we;
            busy      <= 1'b1;
            state     <= ST_ACCESS;
          end else begin
            mem_we <= WEW'(WE_NONE);
          end
        end

        ST_ACCESS: begin
          // ram samples at this edge; the write code must not linger into RESP.
          mem_we <= WEW'(WE_NONE);
          ack0_q <= ~win_id;
          ack1_q <= win_id;
          state  <= ST_RESP;
        end

        ST_RESP: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          rr_ptr <= ~win_id;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          // Unused encoding: recover quietly without touching ram.
          mem_we <= WEW'(WE_NONE);
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Acks are registered; ram's qout is only meaningful during RESP, so the
  // data path is gated by the winner's ack rather than registered again.
  assign m0.ack   = ack0_q;
  assign m1.ack   = ack1_q;
  assign m0.rdata = ack0_q ? mem_rdata : '0;
  assign m1.rdata = ack1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiter instances sharing one clock/reset: dut_a in round-robin
//   mode, dut_b with fixed priority. Each has its own behavioural ram with a
//   registered (one-cycle) read. Inputs change 1 ns after the rising edge and
//   outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int XW = 32;
  localparam int WW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AWIDTH(AW), .XLEN(XW), .WEW(WW)) a_m0 ();
  dmem_arbiter_if #(.AWIDTH(AW), .XLEN(XW), .WEW(WW)) a_m1 ();
  dmem_arbiter_if #(.AWIDTH(AW), .XLEN(XW), .WEW(WW)) b_m0 ();
  dmem_arbiter_if #(.AWIDTH(AW), .XLEN(XW), .WEW(WW)) b_m1 ();

  logic [AW-1:0] a_mem_addr,  b_mem_addr;
  logic [XW-1:0] a_mem_wdata, b_mem_wdata;
  logic [WW-1:0] a_mem_we,    b_mem_we;
  logic [XW-1:0] a_mem_rdata, b_mem_rdata;
  logic          a_busy,      b_busy;

  dmem_arbiter #(.AWIDTH(AW), .XLEN(XW), .WEW(WW), .FIXED_PRIO(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .m0        (a_m0),
    .m1        (a_m1),
    .mem_addr  (a_mem_addr),
    .mem_wdata (a_mem_wdata),
    .mem_we    (a_mem_we),
    .mem_rdata (a_mem_rdata),
    .busy      (a_busy)
  );

  dmem_arbiter #(.AWIDTH(AW), .XLEN(XW), .WEW(WW), .FIXED_PRIO(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .m0        (b_m0),
    .m1        (b_m1),
    .mem_addr  (b_mem_addr),
    .mem_wdata (b_mem_wdata),
    .mem_we    (b_mem_we),
    .mem_rdata (b_mem_rdata),
    .busy      (b_busy)
  );

  // Behavioural rams with a side preload port driven by the stimulus.
  logic [XW-1:0] ram_a [0:(1<<AW)-1];
  logic [XW-1:0] ram_b [0:(1<<AW)-1];
  logic          pl_a_en, pl_b_en;
  logic [AW-1:0] pl_addr;
  logic [XW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_a_en)              ram_a[pl_addr]    <= pl_data;
    else if (a_mem_we != '0)  ram_a[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= ram_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (pl_b_en)              ram_b[pl_addr]    <= pl_data;
    else if (b_mem_we != '0)  ram_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= ram_b[b_mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit to_b, input logic [AW-1:0] addr, input logic [XW-1:0] data);
    pl_addr = addr;
    pl_data = data;
    pl_a_en = !to_b;
    pl_b_en = to_b;
    tick();
    pl_a_en = 1'b0;
    pl_b_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    pl_a_en  = 1'b0;
    pl_b_en  = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    a_m0.req = 1'b0; a_m0.addr = '0; a_m0.wdata = '0; a_m0.we = '0;
    a_m1.req = 1'b0; a_m1.addr = '0; a_m1.wdata = '0; a_m1.we = '0;
    b_m0.req = 1'b0; b_m0.addr = '0; b_m0.wdata = '0; b_m0.we = '0;
    b_m1.req = 1'b0; b_m1.addr = '0; b_m1.wdata = '0; b_m1.we = '0;

    // ---------------- reset ----------------
    tick();
    preload(1'b0, 12'h010, 32'hDEADBEEF);
    preload(1'b1, 12'h010, 32'hDEADBEEF);
    preload(1'b1, 12'h020, 32'h0BADF00D);
    check("rst_busy_a",  a_busy,      0);
    check("rst_we_a",    a_mem_we,    0);
    check("rst_addr_a",  a_mem_addr,  0);
    check("rst_wdata_a", a_mem_wdata, 0);
    check("rst_ack0_a",  a_m0.ack,    0);
    check("rst_ack1_a",  a_m1.ack,    0);
    check("rst_busy_b",  b_busy,      0);
    rst = 1'b0;
    tick();
    check("idle_busy_a", a_busy, 0);

    // ---------------- single m0 read ----------------
    a_m0.req = 1'b1; a_m0.addr = 12'h010; a_m0.we = 3'b000;
    tick();
    check("rd0_addr",  a_mem_addr, 32'h010);
    check("rd0_busy",  a_busy,     1);
    check("rd0_we",    a_mem_we,   0);
    check("rd0_ack_e", a_m0.ack,   0);
    check("rd0_ack1a", a_m1.ack,   0);
    tick();
    check("rd0_ack",   a_m0.ack,   1);
    check("rd0_data",  a_m0.rdata, 32'hDEADBEEF);
    check("rd0_ack1b", a_m1.ack,   0);
    check("rd0_rd1z",  a_m1.rdata, 0);
    a_m0.req = 1'b0;
    tick();
    check("rd0_idle",  a_busy,     0);
    check("rd0_ackl",  a_m0.ack,   0);

    // ---------------- m1 write, then m0 read back ----------------
    a_m1.req = 1'b1; a_m1.addr = 12'h020; a_m1.wdata = 32'h12345678; a_m1.we = 3'b010;
    tick();
    check("wr1_we",    a_mem_we,    3'b010);
    check("wr1_addr",  a_mem_addr,  32'h020);
    check("wr1_wdata", a_mem_wdata, 32'h12345678);
    tick();
    check("wr1_we0",   a_mem_we,    0);
    check("wr1_ack",   a_m1.ack,    1);
    check("wr1_ack0",  a_m0.ack,    0);
    a_m1.req = 1'b0;
    tick();
    check("wr1_weidl", a_mem_we,    0);
    check("wr1_hold",  a_mem_addr,  32'h020);
    a_m0.req = 1'b1; a_m0.addr = 12'h020; a_m0.we = 3'b000;
    tick();
    tick();
    check("rb0_ack",   a_m0.ack,   1);
    check("rb0_data",  a_m0.rdata, 32'h12345678);
    a_m0.req = 1'b0;
    tick();

    // ---------------- round-robin contention from reset ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_m0.req = 1'b1; a_m0.addr = 12'h010; a_m0.we = 3'b000;
    a_m1.req = 1'b1; a_m1.addr = 12'h020; a_m1.we = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d_addr", k), a_mem_addr, (k % 2 == 1) ? 32'h020 : 32'h010);
      tick();
      check($sformatf("rr%0d_ack0", k), a_m0.ack, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_ack1", k), a_m1.ack, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 0) check($sformatf("rr%0d_data", k), a_m0.rdata, 32'hDEADBEEF);
      else            check($sformatf("rr%0d_data", k), a_m1.rdata, 32'h12345678);
      if (k == 3) begin
        a_m0.req = 1'b0;
        a_m1.req = 1'b0;
      end
      tick();
    end
    check("rr_idle", a_busy, 0);

    // ---------------- reset during ACCESS of an m1 write ----------------
    // An m0 read first leaves rr_ptr pointing at m1.
    a_m0.req = 1'b1; a_m0.addr = 12'h010;
    tick();
    tick();
    check("pre_ack0", a_m0.ack, 1);
    a_m0.req = 1'b0;
    tick();
    a_m1.req = 1'b1; a_m1.addr = 12'h030; a_m1.wdata = 32'hCAFEF00D; a_m1.we = 3'b001;
    tick();
    check("rsa_we",   a_mem_we, 3'b001);
    rst = 1'b1;
    a_m1.req = 1'b0;
    tick();
    check("rsa_we0",  a_mem_we, 0);
    check("rsa_busy", a_busy,   0);
    check("rsa_ack1", a_m1.ack, 0);
    rst = 1'b0;
    tick();
    check("rsa_ack1b", a_m1.ack, 0);
    check("rsa_busyb", a_busy,   0);
    a_m0.req = 1'b1; a_m0.addr = 12'h010; a_m0.we = 3'b000;
    a_m1.req = 1'b1; a_m1.addr = 12'h020; a_m1.we = 3'b000;
    tick();
    check("rsa_win_addr", a_mem_addr, 32'h010);
    tick();
    check("rsa_win_ack0", a_m0.ack, 1);
    check("rsa_win_ack1", a_m1.ack, 0);
    a_m0.req = 1'b0;
    a_m1.req = 1'b0;
    tick();

    // ---------------- m0 drops req after capture ----------------
    a_m0.req = 1'b1; a_m0.addr = 12'h020; a_m0.we = 3'b000;
    tick();
    a_m0.req = 1'b0;
    tick();
    check("drop_ack",  a_m0.ack,   1);
    check("drop_data", a_m0.rdata, 32'h12345678);
    tick();
    check("drop_busy", a_busy,     0);
    check("drop_ackl", a_m0.ack,   0);

    // ---------------- fixed priority (dut_b) ----------------
    b_m0.req = 1'b1; b_m0.addr = 12'h010; b_m0.we = 3'b000;
    b_m1.req = 1'b1; b_m1.addr = 12'h020; b_m1.we = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fp%0d_addr", k), b_mem_addr, 32'h010);
      tick();
      check($sformatf("fp%0d_ack0", k), b_m0.ack, 1);
      check($sformatf("fp%0d_ack1", k), b_m1.ack, 0);
      if (k == 2) b_m0.req = 1'b0;
      tick();
    end
    tick();
    check("fp_m1_addr", b_mem_addr, 32'h020);
    tick();
    check("fp_m1_ack1", b_m1.ack,   1);
    check("fp_m1_ack0", b_m0.ack,   0);
    check("fp_m1_data", b_m1.rdata, 32'h0BADF00D);
    b_m1.req = 1'b0;
    tick();
    check("fp_idle", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single data-memory port (ram: addr/qin/we/qout, synchronous 1-cycle read).
- Requester 0 is the core load/store path.
- Requester 1 is the debug/loader master, used for firmware upload and memory inspection without halting the bus.
- Sits between top_core and ram in the board top: serialises accesses and returns read data with a per-requester ack.

Parameters:
- AWIDTH, 12, data-memory address width (matches core_general.vh)
- XLEN, 32, data width
- WEW, 3, width of the write-enable/size code; nonzero means write, value passed through opaque
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
- clk  in  1  global clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  requester 0 access request; held until m0_ack
- m0_addr  in  AWIDTH  requester 0 address
- m0_wdata  in  XLEN  requester 0 write data
- m0_we  in  WEW  requester 0 write code (0 = read)
- m0_ack  out  1  one-cycle completion pulse to requester 0
- m0_rdata  out  XLEN  read data to requester 0, valid only while m0_ack=1
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata: same as m0_* for requester 1
- mem_addr  out  AWIDTH  address to ram
- mem_wdata  out  XLEN  write data to ram
- mem_we  out  WEW  write code to ram
- mem_rdata  in  XLEN  ram read data (qout), valid the cycle after address is sampled
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, rr_ptr=0 (requester 0 favoured), all outputs 0. Applies from any state.
- A reset during ACCESS or RESP drops the transaction: no ack is issued and mem_we is 0 from the next cycle.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a winner and register its addr/wdata/we into mem_*; latch win_id; go to ACCESS.
  - With no req, stay in IDLE; mem_we=0.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high, FIXED_PRIO=0: winner = rr_ptr.
  - Both high, FIXED_PRIO=1: winner = 0.
- ACCESS: mem_addr/mem_wdata/mem_we held; ram samples at the end of this cycle; go to RESP.
- RESP:
  - mem_we forced to 0.
  - ack of win_id = 1; rdata of win_id = mem_rdata. The non-winner's ack = 0 and rdata = 0.
  - Go to IDLE; rr_ptr <= ~win_id (updated even when FIXED_PRIO=1, but ignored in that mode).
- mem_we is nonzero only in ACCESS. It is registered, so there are no glitches onto ram.
- Latency: req sampled high in cycle T -> ack in cycle T+2. Throughput: one access per 3 cycles.
- Under continuous contention with FIXED_PRIO=0, grants alternate 0,1,0,1.
- Requesters hold req and operands stable until ack. If req drops after capture, the captured transaction still completes and ack still pulses.
- A requester must drop req (or present a new access) in the cycle after ack. A req still high in IDLE is treated as a new request.
- Write accesses also pulse ack in RESP; rdata during a write ack is don't-care (drives mem_rdata).
- mem_addr/mem_wdata retain their last values in IDLE and RESP; only mem_we is cleared.

Decomposition:
- Shared package/include (alongside core_general.vh):
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - WE_NONE=0 constant
  - AWIDTH/XLEN reused from core_general.vh
- One natural sub-module: dmem_arb_pick, a combinational 2-way winner select from (req0, req1, rr_ptr, FIXED_PRIO) -> grant_id, grant_valid.
- FSM, operand registers and response muxing stay in dmem_arbiter.

Test Plan:
- Reset then single m0 read: ram[0x010]=0xDEADBEEF, m0_req=1, m0_addr=0x010, m0_we=0 at T.
  -> mem_addr=0x010 at T+1, m0_ack=1 and m0_rdata=0xDEADBEEF at T+2, m1_ack=0 throughout.
- m1 write then m0 read of the same address: m1 writes 0x12345678 to 0x020 (we=3'b010).
  -> mem_we=3'b010 for exactly one cycle (ACCESS), m1_ack at T+2.
  -> A following m0 read of 0x020 returns 0x12345678.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 transactions.
  -> ack order m0,m1,m0,m1, each 3 cycles apart; rr_ptr toggles each RESP.
- Same stimulus with FIXED_PRIO=1, m0 re-requests immediately after each ack.
  -> m0 granted every time while m0_req stays high; m1 granted on the first IDLE where m0_req=0.
- rst=1 asserted in ACCESS of an m1 write.
  -> no m1_ack, mem_we=0 from next cycle, busy=0, state IDLE.
  -> The next contended request goes to m0 (rr_ptr=0).
- m0 drops req in the cycle after capture (ACCESS).
  -> m0_ack still pulses at T+2 with correct rdata; arbiter returns to IDLE; busy=0 at T+3.
